// File: rtl/result_collector_if.sv
// result_collector_if: two valid/stall/flush result channels plus the merged valid/ready output
interface result_collector_if #(parameter int WIDTH = 32);
    logic             in_valid_1;
    logic             in_valid_2;
    logic [WIDTH-1:0] in_data_1;
    logic [WIDTH-1:0] in_data_2;
    logic             in_flush_1;
    logic             in_flush_2;
    logic             stall_1;
    logic             stall_2;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_chan;
    logic             out_ready;

    modport master (
        output in_valid_1, in_valid_2, in_data_1, in_data_2, in_flush_1, in_flush_2, out_ready,
        input  stall_1, stall_2, out_valid, out_data, out_chan
    );

    modport slave (
        input  in_valid_1, in_valid_2, in_data_1, in_data_2, in_flush_1, in_flush_2, out_ready,
        output stall_1, stall_2, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/result_collector.sv
// result_collector: two per-channel FIFOs merged round-robin onto one tagged output; RESULT_COLLECTOR_CNT_EN adds beat counters
module result_collector #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic reset_n,
    result_collector_if.slave bus
`ifdef RESULT_COLLECTOR_CNT_EN
    ,
    output logic [15:0] cnt_1,
    output logic [15:0] cnt_2
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [2][DEPTH];
    logic [PW-1:0]    wp [2];
    logic [PW-1:0]    rp [2];
    logic [CW-1:0]    count [2];
    logic [WIDTH-1:0] data [2];
    logic [1:0]       valid, flush, push, pop, full, ne;
    logic             last_grant, lock, lock_chan, grant, hs;

    assign valid = {bus.in_valid_2, bus.in_valid_1};
    assign flush = {bus.in_flush_2, bus.in_flush_1};
    assign data[0] = bus.in_data_1;
    assign data[1] = bus.in_data_2;
    assign bus.stall_1 = full[0];
    assign bus.stall_2 = full[1];
    assign bus.out_valid = ne[grant];
    assign bus.out_data = ne[grant] ? mem[grant][rp[grant]] : '0;
    assign bus.out_chan = grant;
    assign hs = ne[grant] & bus.out_ready;

    // Stall from registered count only; a locked grant overrides the round-robin choice
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            full[k] = count[k] == CW'(DEPTH);
            ne[k] = count[k] != '0;
            push[k] = valid[k] & ~full[k] & ~flush[k];
        end
        grant = lock ? lock_chan : (&ne ? ~last_grant : ne[1]);
        pop = {2{hs}} & (grant ? 2'b10 : 2'b01);
    end

    // Pointers, counts and arbiter state; flush clears its channel and beats the same-cycle push
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                wp[k] <= '0;
                rp[k] <= '0;
                count[k] <= '0;
            end
            last_grant <= 1'b1;
            lock <= 1'b0;
            lock_chan <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                wp[k] <= flush[k] ? '0 : wp[k] + PW'(push[k]);
                rp[k] <= flush[k] ? '0 : rp[k] + PW'(pop[k]);
                count[k] <= flush[k] ? '0 : count[k] + CW'(push[k]) - CW'(pop[k]);
            end
            if (hs) last_grant <= grant;
            lock <= ne[grant] & ~bus.out_ready & ~flush[grant];
            lock_chan <= grant;
        end
    end

    // Storage needs no reset; validity is tracked by the counts
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (push[k]) mem[k][wp[k]] <= data[k];
    end

`ifdef RESULT_COLLECTOR_CNT_EN
    // Accepted-beat counters, cleared by their own channel's flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_1 <= '0;
            cnt_2 <= '0;
        end else begin
            cnt_1 <= flush[0] ? '0 : cnt_1 + 16'(push[0]);
            cnt_2 <= flush[1] ? '0 : cnt_2 + 16'(push[1]);
        end
    end
`endif
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: directed checks of accept, stall, round-robin, lock, flush and async reset
module tb_result_collector;
    logic clk = 1'b0;
    logic reset_n;
    int errors = 0;
    int checks = 0;

    result_collector_if #(.WIDTH(32)) bus ();
`ifdef RESULT_COLLECTOR_CNT_EN
    logic [15:0] cnt_1, cnt_2;
`endif

    result_collector #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
`ifdef RESULT_COLLECTOR_CNT_EN
        ,
        .cnt_1(cnt_1),
        .cnt_2(cnt_2)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid_1 = 0;
        bus.in_valid_2 = 0;
        bus.in_flush_1 = 0;
        bus.in_flush_2 = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_data"}, bus.out_data, 0);
        check({tag, "_chan"}, bus.out_chan, 0);
        check({tag, "_stall1"}, bus.stall_1, 0);
        check({tag, "_stall2"}, bus.stall_2, 0);
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();
        bus.in_data_1 = 0;
        bus.in_data_2 = 0;
        bus.out_ready = 0;
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        reset_n = 1;

        // single beat
        bus.out_ready = 1;
        bus.in_valid_1 = 1;
        bus.in_data_1 = 32'hA5A5_0001;
        step();
        bus.in_valid_1 = 0;
        check("single_valid", bus.out_valid, 1);
        check("single_data", bus.out_data, 32'hA5A5_0001);
        check("single_chan", bus.out_chan, 0);
`ifdef RESULT_COLLECTOR_CNT_EN
        check("cnt1", cnt_1, 1);
`endif
        step();
        check("single_after", bus.out_valid, 0);

        // fill channel 2 to stall
        bus.out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid_2 = 1;
            bus.in_data_2 = 32'h200 + i;
            step();
        end
        check("fill_stall2", bus.stall_2, 1);
        check("fill_stall1", bus.stall_1, 0);
        bus.in_data_2 = 32'h2FF;
        step();
        bus.in_valid_2 = 0;
        check("fill_held_stall", bus.stall_2, 1);
        check("fill_head", bus.out_data, 32'h200);
        check("fill_chan", bus.out_chan, 1);
        bus.out_ready = 1;
        step();
        check("drain_stall_fall", bus.stall_2, 0);
        for (int i = 1; i < 4; i++) begin
            check("drain_data", bus.out_data, 32'h200 + i);
            check("drain_chan", bus.out_chan, 1);
            step();
        end
        check("drain_empty", bus.out_valid, 0);

        // round robin
        bus.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid_1 = 1;
            bus.in_valid_2 = 1;
            bus.in_data_1 = 32'h100 + i;
            bus.in_data_2 = 32'h300 + i;
            step();
        end
        idle_inputs();
        bus.out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            check("rr_chan", bus.out_chan, i % 2);
            check("rr_data", bus.out_data, (i % 2 ? 32'h300 : 32'h100) + i / 2);
            step();
        end
        check("rr_empty", bus.out_valid, 0);

        // grant lock: make last_grant = channel 1 so an unlocked tie would pick channel 2
        bus.in_valid_1 = 1;
        bus.in_data_1 = 32'hAA;
        step();
        bus.in_valid_1 = 0;
        check("pre_lock_data", bus.out_data, 32'hAA);
        step();
        bus.out_ready = 0;
        bus.in_valid_1 = 1;
        bus.in_data_1 = 32'h111;
        step();
        bus.in_valid_1 = 0;
        check("lock_first", bus.out_data, 32'h111);
        bus.in_valid_2 = 1;
        bus.in_data_2 = 32'h222;
        step();
        bus.in_valid_2 = 0;
        for (int i = 0; i < 2; i++) begin
            check("lock_data", bus.out_data, 32'h111);
            check("lock_chan", bus.out_chan, 0);
            step();
        end
        bus.out_ready = 1;
        step();
        check("unlock_data", bus.out_data, 32'h222);
        check("unlock_chan", bus.out_chan, 1);
        step();
        check("unlock_empty", bus.out_valid, 0);

        // flush channel 1 while presented and locked
        bus.out_ready = 0;
        bus.in_valid_1 = 1;
        bus.in_valid_2 = 1;
        bus.in_data_1 = 32'h501;
        bus.in_data_2 = 32'h601;
        step();
        bus.in_valid_2 = 0;
        bus.in_data_1 = 32'h502;
        step();
        check("flush_pre_chan", bus.out_chan, 0);
        check("flush_pre_data", bus.out_data, 32'h501);
        bus.in_flush_1 = 1;
        bus.in_data_1 = 32'h5FF;
        step();
        idle_inputs();
        check("flush_valid", bus.out_valid, 1);
        check("flush_chan", bus.out_chan, 1);
        check("flush_data", bus.out_data, 32'h601);
        step();
        check("flush_hold", bus.out_data, 32'h601);
        bus.out_ready = 1;
        step();
        check("flush_ch1_empty", bus.out_valid, 0);

        // async reset mid-stream, after a channel-1 pop left last_grant = channel 1
        bus.out_ready = 0;
        bus.in_valid_1 = 1;
        bus.in_valid_2 = 1;
        bus.in_data_1 = 32'h701;
        bus.in_data_2 = 32'h801;
        step();
        idle_inputs();
        bus.out_ready = 1;
        step();
        bus.out_ready = 0;
        bus.in_valid_1 = 1;
        bus.in_data_1 = 32'h702;
        step();
        bus.in_valid_1 = 0;
        check("prerst_data", bus.out_data, 32'h801);
        #1;
        reset_n = 0;
        #1;
        check_reset_outputs("async");
        #1;
        reset_n = 1;
        bus.in_valid_1 = 1;
        bus.in_valid_2 = 1;
        bus.in_data_1 = 32'hA01;
        bus.in_data_2 = 32'hB01;
        step();
        idle_inputs();
        check("post_rst_chan", bus.out_chan, 0);
        check("post_rst_data", bus.out_data, 32'hA01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
